// File: rtl/rx_valid_edge_sync.sv
// Multi-channel receive-valid edge detector: optional synchroniser, glitch filter,
// single-cycle event pulse and a sticky pending/overrun handshake per channel.
module rx_valid_edge_sync #(
  parameter int CHANNELS    = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 1,
  parameter int EDGE_MODE   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] valid_reg,
  input  logic [CHANNELS-1:0] ack,
  output logic [CHANNELS-1:0] Rx_valid,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] overrun,
  output logic [CHANNELS-1:0] level
);

  localparam int CNT_W = $clog2(FILTER_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);
  // Mode 3 is not a legal selection and behaves as rising-edge only.
  localparam int MODE = (EDGE_MODE == 1 || EDGE_MODE == 2) ? EDGE_MODE : 0;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic             w_s;
    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rx;
    logic             r_pend;
    logic             r_ovr;
    logic             w_flip;
    logic             w_rise;
    logic             w_fall;
    logic             w_event;

    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = valid_reg[g];
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_sync <= '0;
        end else begin
          r_sync <= (r_sync << 1) | SYNC_STAGES'(valid_reg[g]);
        end
      end

      assign w_s = r_sync[SYNC_STAGES-1];
    end

    // The filtered level flips only once the disagreement has lasted FILTER_LEN edges.
    assign w_flip  = (w_s != r_state[0]) && (r_cnt == CNT_MAX);
    assign w_rise  = w_flip && (r_state == IDLE);
    assign w_fall  = w_flip && (r_state == ACTIVE);
    assign w_event = (MODE == 2) ? w_flip :
                     (MODE == 1) ? w_fall : w_rise;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_rx    <= 1'b0;
        r_pend  <= 1'b0;
        r_ovr   <= 1'b0;
      end else begin
        if (w_s == r_state[0]) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_cnt   <= '0;
          r_state <= w_s ? ACTIVE : IDLE;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end

        r_rx <= w_event;

        // A new event outranks a same-cycle ack: the acked event is consumed, the new one is held.
        if (w_event && r_pend && !ack[g]) begin
          r_ovr <= 1'b1;
        end else if (w_event) begin
          r_pend <= 1'b1;
        end else if (ack[g]) begin
          r_pend <= 1'b0;
          r_ovr  <= 1'b0;
        end
      end
    end

    assign Rx_valid[g] = r_rx;
    assign pending[g]  = r_pend;
    assign overrun[g]  = r_ovr;
    assign level[g]    = r_state[0];
  end

endmodule

// File: tb/tb_rx_valid_edge_sync.sv
// Bench for rx_valid_edge_sync: five parameterisations checked every cycle against a
// sliding-window reference model, plus directed latency/filter/handshake/reset steps.
module tb_rx_valid_edge_sync;

  logic clk;
  logic rst_n;

  logic va, aa, rxA, pdA, ovA, lvA;
  logic vb, ab, rxB, pdB, ovB, lvB;
  logic vc, ac, rxC, pdC, ovC, lvC;
  logic ad, rxD, pdD, ovD, lvD;
  logic [7:0] ve, ae, rxE, pdE, ovE, lvE;

  int checks;
  int failures;

  localparam int NI = 5;
  localparam int CFG_SYNC [NI] = '{2, 0, 2, 2, 2};
  localparam int CFG_FL   [NI] = '{1, 4, 1, 1, 3};
  localparam int CFG_EM   [NI] = '{0, 0, 2, 1, 2};
  localparam int CFG_NCH  [NI] = '{1, 1, 1, 1, 8};

  rx_valid_edge_sync #(.CHANNELS(1), .SYNC_STAGES(2), .FILTER_LEN(1), .EDGE_MODE(0)) u_a (
    .clk(clk), .reset(rst_n), .valid_reg(va), .ack(aa),
    .Rx_valid(rxA), .pending(pdA), .overrun(ovA), .level(lvA));
  rx_valid_edge_sync #(.CHANNELS(1), .SYNC_STAGES(0), .FILTER_LEN(4), .EDGE_MODE(0)) u_b (
    .clk(clk), .reset(rst_n), .valid_reg(vb), .ack(ab),
    .Rx_valid(rxB), .pending(pdB), .overrun(ovB), .level(lvB));
  rx_valid_edge_sync #(.CHANNELS(1), .SYNC_STAGES(2), .FILTER_LEN(1), .EDGE_MODE(2)) u_c (
    .clk(clk), .reset(rst_n), .valid_reg(vc), .ack(ac),
    .Rx_valid(rxC), .pending(pdC), .overrun(ovC), .level(lvC));
  rx_valid_edge_sync #(.CHANNELS(1), .SYNC_STAGES(2), .FILTER_LEN(1), .EDGE_MODE(1)) u_d (
    .clk(clk), .reset(rst_n), .valid_reg(vc), .ack(ad),
    .Rx_valid(rxD), .pending(pdD), .overrun(ovD), .level(lvD));
  rx_valid_edge_sync #(.CHANNELS(8), .SYNC_STAGES(2), .FILTER_LEN(3), .EDGE_MODE(2)) u_e (
    .clk(clk), .reset(rst_n), .valid_reg(ve), .ack(ae),
    .Rx_valid(rxE), .pending(pdE), .overrun(ovE), .level(lvE));

  logic [7:0] in_v [NI];
  logic [7:0] in_a [NI];
  logic [7:0] got_rx [NI];
  logic [7:0] got_pd [NI];
  logic [7:0] got_ov [NI];
  logic [7:0] got_lv [NI];

  assign in_v[0] = {7'b0, va};  assign in_a[0] = {7'b0, aa};
  assign in_v[1] = {7'b0, vb};  assign in_a[1] = {7'b0, ab};
  assign in_v[2] = {7'b0, vc};  assign in_a[2] = {7'b0, ac};
  assign in_v[3] = {7'b0, vc};  assign in_a[3] = {7'b0, ad};
  assign in_v[4] = ve;          assign in_a[4] = ae;

  assign got_rx[0] = {7'b0, rxA}; assign got_pd[0] = {7'b0, pdA};
  assign got_ov[0] = {7'b0, ovA}; assign got_lv[0] = {7'b0, lvA};
  assign got_rx[1] = {7'b0, rxB}; assign got_pd[1] = {7'b0, pdB};
  assign got_ov[1] = {7'b0, ovB}; assign got_lv[1] = {7'b0, lvB};
  assign got_rx[2] = {7'b0, rxC}; assign got_pd[2] = {7'b0, pdC};
  assign got_ov[2] = {7'b0, ovC}; assign got_lv[2] = {7'b0, lvC};
  assign got_rx[3] = {7'b0, rxD}; assign got_pd[3] = {7'b0, pdD};
  assign got_ov[3] = {7'b0, ovD}; assign got_lv[3] = {7'b0, lvD};
  assign got_rx[4] = rxE;         assign got_pd[4] = pdE;
  assign got_ov[4] = ovE;         assign got_lv[4] = lvE;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: history of raw input samples per channel. The synchronised value seen at
  // an edge is the sample taken SYNC edges earlier; the filtered level toggles when the last
  // FILTER_LEN synchronised values all disagree with it.
  logic [15:0] m_vh   [NI][8];
  logic        m_lvl  [NI][8];
  logic        m_rx   [NI][8];
  logic        m_pend [NI][8];
  logic        m_ovr  [NI][8];

  always @(posedge clk or negedge rst_n) begin
    logic [15:0] vh;
    logic        flip;
    logic        ev;
    if (!rst_n) begin
      for (int i = 0; i < NI; i++)
        for (int c = 0; c < 8; c++) begin
          m_vh[i][c]   <= '0;
          m_lvl[i][c]  <= 1'b0;
          m_rx[i][c]   <= 1'b0;
          m_pend[i][c] <= 1'b0;
          m_ovr[i][c]  <= 1'b0;
        end
    end else begin
      for (int i = 0; i < NI; i++)
        for (int c = 0; c < CFG_NCH[i]; c++) begin
          vh   = {m_vh[i][c][14:0], in_v[i][c]};
          flip = 1'b1;
          for (int k = 0; k < CFG_FL[i]; k++)
            if (vh[CFG_SYNC[i] + k] == m_lvl[i][c]) flip = 1'b0;
          ev = flip && ((CFG_EM[i] == 2) ||
                        (CFG_EM[i] == 1 && m_lvl[i][c]) ||
                        ((CFG_EM[i] == 0 || CFG_EM[i] == 3) && !m_lvl[i][c]));
          m_vh[i][c] <= vh;
          if (flip) m_lvl[i][c] <= ~m_lvl[i][c];
          m_rx[i][c] <= ev;
          if (ev && m_pend[i][c] && !in_a[i][c]) m_ovr[i][c] <= 1'b1;
          else if (ev) m_pend[i][c] <= 1'b1;
          else if (in_a[i][c]) begin
            m_pend[i][c] <= 1'b0;
            m_ovr[i][c]  <= 1'b0;
          end
        end
    end
  end

  task automatic chk(input string tag, input int id, input int ch, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s inst=%0d ch=%0d observed=%b expected=%b", tag, id, ch, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++)
      for (int c = 0; c < CFG_NCH[i]; c++) begin
        chk("model_rx",  i, c, got_rx[i][c], m_rx[i][c]);
        chk("model_pd",  i, c, got_pd[i][c], m_pend[i][c]);
        chk("model_ov",  i, c, got_ov[i][c], m_ovr[i][c]);
        chk("model_lvl", i, c, got_lv[i][c], m_lvl[i][c]);
      end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_rx"}, 0, 0, rxA, 1'b0);
    chk({tag, "_pd"}, 0, 0, pdA, 1'b0);
    chk({tag, "_ov"}, 0, 0, ovA, 1'b0);
    chk({tag, "_lv"}, 0, 0, lvA, 1'b0);
  endtask

  int pc, pd_cnt, first_c, second_c;

  initial begin
    checks = 0; failures = 0;
    va = 0; aa = 0; vb = 0; ab = 0; vc = 0; ac = 0; ad = 0; ve = '0; ae = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Outputs held at zero during reset, even with inputs active.
    @(negedge clk);
    va = 1; vb = 1; vc = 1; ve = 8'hFF;
    repeat (3) step();
    chk_a_zero("reset");
    chk("reset_rxE", 4, 0, |rxE, 1'b0);
    chk("reset_lvE", 4, 0, |lvE, 1'b0);
    va = 0; vb = 0; vc = 0; ve = '0;
    rst_n = 1'b1;
    step();

    // Latency 3 with defaults, one pulse for a held level.
    va = 1;
    step(); chk("lat_e1", 0, 0, rxA, 1'b0);
    step(); chk("lat_e2", 0, 0, rxA, 1'b0);
    step(); chk("lat_e3", 0, 0, rxA, 1'b1);
    step(); chk("lat_e4", 0, 0, rxA, 1'b0);
    chk("lat_pd", 0, 0, pdA, 1'b1);
    chk("lat_lv", 0, 0, lvA, 1'b1);
    pc = 0;
    repeat (16) begin step(); pc += int'(rxA); end
    chk_int("held_no_repulse", pc, 0);

    // Glitch of 3 cycles filtered with FILTER_LEN=4, then a 4-cycle level passes.
    vb = 1;
    repeat (3) step();
    vb = 0;
    pc = 0;
    repeat (6) begin step(); pc += int'(rxB); chk("glitch_lv", 1, 0, lvB, 1'b0); end
    chk_int("glitch_pulses", pc, 0);
    vb = 1;
    repeat (3) step();
    chk("filt_e3", 1, 0, rxB, 1'b0);
    step(); chk("filt_e4", 1, 0, rxB, 1'b1);
    chk("filt_lv", 1, 0, lvB, 1'b1);
    vb = 0;
    step(); chk("filt_e5", 1, 0, rxB, 1'b0);

    // Both-edge and falling-edge modes on a 10-cycle high level.
    vc = 1;
    pc = 0; pd_cnt = 0; first_c = -1; second_c = -1;
    for (int t = 0; t < 24; t++) begin
      if (t == 10) vc = 0;
      step();
      if (rxC) begin
        pc++;
        if (first_c < 0) first_c = t; else second_c = t;
      end
      pd_cnt += int'(rxD);
    end
    chk_int("both_pulses", pc, 2);
    chk_int("both_spacing", second_c - first_c, 10);
    chk_int("fall_pulses", pd_cnt, 1);
    chk("fall_lv", 3, 0, lvD, 1'b0);

    // Overrun on a second unacked event, then ack clears both flags.
    va = 0; repeat (4) step();
    va = 1; repeat (4) step();
    chk("ovr_set", 0, 0, ovA, 1'b1);
    chk("ovr_pd", 0, 0, pdA, 1'b1);
    aa = 1; step(); aa = 0;
    chk("ack_pd", 0, 0, pdA, 1'b0);
    chk("ack_ov", 0, 0, ovA, 1'b0);
    aa = 1; step(); aa = 0;
    chk("ack_idle_pd", 0, 0, pdA, 1'b0);
    va = 0; repeat (4) step();
    va = 1; repeat (4) step();
    chk("ev_pd", 0, 0, pdA, 1'b1);
    chk("ev_ov", 0, 0, ovA, 1'b0);
    va = 0; repeat (4) step();
    va = 1;
    step(); step();
    aa = 1; step(); aa = 0;
    chk("coinc_rx", 0, 0, rxA, 1'b1);
    chk("coinc_pd", 0, 0, pdA, 1'b1);
    chk("coinc_ov", 0, 0, ovA, 1'b0);

    // Asynchronous reset while the pulse is high, released with the input held high.
    #2 rst_n = 1'b0;
    #1 chk_a_zero("async_rst");
    check_all();
    @(negedge clk);
    step();
    rst_n = 1'b1;
    step(); chk("rel_e1", 0, 0, rxA, 1'b0);
    step(); chk("rel_e2", 0, 0, rxA, 1'b0);
    step(); chk("rel_e3", 0, 0, rxA, 1'b1);
    step(); chk("rel_e4", 0, 0, rxA, 1'b0);

    // Eight channels with staggered random levels and acks against the model.
    pc = 0;
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < 8; c++) begin
        if ($urandom_range(0, 3 + c) == 0) ve[c] = ~ve[c];
        ae[c] = ($urandom_range(0, 7) == 0);
      end
      step();
      pc += $countones(rxE);
    end
    checks++;
    assert (pc > 20) else begin
      failures++;
      $error("FAIL rand_activity observed=%0d expected=>20", pc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_valid_edge_sync.md
# rx_valid_edge_sync

Parametrised, multi-channel successor to the UART receive valid-pulse generator. Each channel optionally synchronises an asynchronous level `valid_reg` into the `clk` domain and glitch-filters it. It then emits a single-cycle registered `Rx_valid` pulse on the selected edge(s). A sticky `pending`/`ack` handshake and `overrun` flag let a slow consumer capture events without losing them silently. It sits between the UART receiver core(s) and the RX FIFO/interrupt logic.

## Interface
- `CHANNELS`, 1: number of independent channels (1..32).
- `SYNC_STAGES`, 2: synchroniser flops per channel (0..4; 0 = input already in `clk` domain, no flops).
- `FILTER_LEN`, 1: consecutive cycles the synchronised level must differ from the filtered level before the filtered level changes (1..255).
- `EDGE_MODE`, 0: 0 = rising edge, 1 = falling edge, 2 = both edges generate events.

- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `valid_reg`  in  CHANNELS  per-channel level input (may be asynchronous when SYNC_STAGES ≥ 2).
- `ack`  in  CHANNELS  per-channel acknowledge; clears `pending` and `overrun`.
- `Rx_valid`  out  CHANNELS  registered one-cycle event pulse.
- `pending`  out  CHANNELS  sticky event flag.
- `overrun`  out  CHANNELS  sticky flag: event arrived while `pending` was set and not acked.
- `level`  out  CHANNELS  filtered level (FSM state: 0 = IDLE, 1 = ACTIVE).

## Operation
Per channel, fully independent:
- Synchroniser: shift chain of SYNC_STAGES flops, reset 0. `s` = last stage, or `valid_reg` directly when SYNC_STAGES = 0.
- Filter counter `cnt`, width clog2(FILTER_LEN)+1, reset 0. Each edge:
  - if `s` == `level`: `cnt` <= 0.
  - else if `cnt` == FILTER_LEN−1: `level` <= `s`, `cnt` <= 0.
  - else: `cnt` <= `cnt`+1.
- FSM states:
  - IDLE (`level` = 0) → ACTIVE on filter rise.
  - ACTIVE (`level` = 1) → IDLE on filter fall.
  - No other transitions.
- Event = the transition selected by EDGE_MODE. EDGE_MODE 3 is illegal; treat it as 0.
- `Rx_valid` <= event, registered at the same edge that updates `level`. A level held high produces exactly one pulse.
- `pending`/`overrun` update at each edge, priority top-down:
  - event & `pending` & !`ack`: `overrun` <= 1, `pending` stays 1.
  - event: `pending` <= 1. This includes event with simultaneous `ack`: the new event wins and `overrun` is unchanged, because the old event is consumed.
  - `ack`: `pending` <= 0, `overrun` <= 0.
  - `ack` with `pending` = 0 and no event: no effect.
- Glitches shorter than FILTER_LEN cycles at `s` produce no event and leave `level` unchanged.

## Timing
- Reset values: `Rx_valid`, `pending`, `overrun`, `level`, `cnt` and all sync flops are 0. Reset assertion clears them asynchronously, mid-pulse included.
- Latency L = SYNC_STAGES + FILTER_LEN rising edges, counted from the first edge that samples the new `valid_reg` level to the edge after which `Rx_valid` is high. Default L = 3.
- `Rx_valid` width is exactly 1 cycle. Minimum spacing between events on one channel is FILTER_LEN cycles.
- `pending` rises in the same cycle as `Rx_valid`. It falls one edge after `ack` is sampled high.
- Reset release with `valid_reg` already high: `level` starts at 0, so a rise event fires L edges after release. This is intentional: the consumer sees the line as newly valid.
- Channel outputs never combinationally depend on inputs; all outputs are flop outputs.

## Test plan
- Reset/latency, defaults, CHANNELS = 1: release reset, raise `valid_reg` and hold 20 cycles → `Rx_valid` = 1 for exactly one cycle, 3 edges after first sample. `pending` = 1, `level` = 1 thereafter. All outputs are 0 during reset.
- Glitch filter, FILTER_LEN = 4, SYNC_STAGES = 0: pulse `valid_reg` high for 3 cycles → no `Rx_valid`, `level` stays 0. Then hold high for 4 cycles → one pulse 4 edges after the rise.
- EDGE_MODE = 2, defaults otherwise: high for 10 cycles, then low → two pulses 10 cycles apart, `level` 1 then 0. EDGE_MODE = 1 with the same stimulus → only the falling-edge pulse.
- Handshake/overrun: two events with no `ack` → `overrun` = 1, `pending` = 1. `ack` one cycle → both 0 the next cycle. Event coincident with `ack` while `pending` = 1 → `pending` = 1, `overrun` = 0.
- Multi-channel, CHANNELS = 8: drive staggered random levels per channel → pulses, flags and latencies match an independent per-channel model, with no cross-channel interaction.
- Reset mid-operation: assert `reset` while `Rx_valid` is high and `cnt` ≠ 0 → all outputs 0 immediately. Release with `valid_reg` high → one rise pulse after L edges.
